// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Inputs: clock, reset (async active-low), load-use operands (ID_EX_MemRead, ID_EX_rt, IF_ID_rs, IF_ID_rt),
// branch_taken redirect, data-memory handshake (dm_req, dm_ready).
// Outputs: stage enables (pc_en, IF_ID_en, ID_EX_en, EX_MEM_en), flushes (IF_ID_flush, ID_EX_flush),
// MEM_WB_bubble, sticky mem_fault, saturating stall_cnt / flush_cnt.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 4,
  parameter int PERF_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ID_EX_MemRead,
  input  logic [4:0]        ID_EX_rt,
  input  logic [4:0]        IF_ID_rs,
  input  logic [4:0]        IF_ID_rt,
  input  logic              branch_taken,
  input  logic              dm_req,
  input  logic              dm_ready,
  output logic              pc_en,
  output logic              IF_ID_en,
  output logic              ID_EX_en,
  output logic              EX_MEM_en,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic              MEM_WB_bubble,
  output logic              mem_fault,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, FAULT = 2'd2;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic mem_fault_q, mem_fault_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic lu, mw, frz, br, lus;
  always_comb begin
    lu = ID_EX_MemRead & (ID_EX_rt != 5'd0) & ((ID_EX_rt == IF_ID_rs) | (ID_EX_rt == IF_ID_rt));
    mw = dm_req & ~dm_ready;
    // the MEM_WAIT release cycle falls through to the RUN hazard rules
    frz = (state_q == FAULT) | (state_q == MEM_WAIT ? ~dm_ready : (state_q == RUN) & mw);
    br = ~frz & branch_taken;
    lus = ~frz & ~branch_taken & lu;
    pc_en = reset & ~frz & ~lus;
    IF_ID_en = reset & ~frz & ~lus;
    ID_EX_en = reset & ~frz;
    EX_MEM_en = reset & ~frz;
    IF_ID_flush = reset & br;
    ID_EX_flush = reset & (br | lus);
    MEM_WB_bubble = ~reset | frz;
    state_d = state_q == RUN ? (mw ? MEM_WAIT : RUN) :
              state_q == MEM_WAIT ? (dm_ready ? RUN : (wait_cnt_q == TMO ? FAULT : MEM_WAIT)) :
              state_q == FAULT ? FAULT : RUN;
    wait_cnt_d = state_d == MEM_WAIT ? wait_cnt_q + CNT_W'(1) : '0;
    mem_fault_d = mem_fault_q | (state_d == FAULT);
    stall_cnt_d = (~pc_en & ~&stall_cnt_q) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
    flush_cnt_d = (br & ~&flush_cnt_q) ? flush_cnt_q + PERF_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_cnt_q <= '0;
      mem_fault_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign mem_fault = mem_fault_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int TMO = 4, PW = 4, SAT = (1 << PW) - 1;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b0, mr = 1'b0, bt = 1'b0, rq = 1'b0, rd = 1'b0;
  logic [4:0] xrt = '0, rs = '0, rt = '0;
  logic pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_fault;
  logic [PW-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  bit m_fault, m_wait, e_frz, e_br, e_lus;
  int m_k, m_stall, m_flush;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(4), .PERF_W(PW)) dut (
    .clock(clock), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_rt(xrt), .IF_ID_rs(rs), .IF_ID_rt(rt),
    .branch_taken(bt), .dm_req(rq), .dm_ready(rd), .pc_en(pc_en), .IF_ID_en(IF_ID_en),
    .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .MEM_WB_bubble(MEM_WB_bubble), .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic drive(input bit r, input bit m, input int a, input int b, input int c,
                       input bit t, input bit q, input bit d);
    bit hz;
    reset = r; mr = m; xrt = a[4:0]; rs = b[4:0]; rt = c[4:0]; bt = t; rq = q; rd = d;
    if (!r) begin
      m_fault = 0; m_wait = 0; m_k = 0; m_stall = 0; m_flush = 0;
    end
    #1;
    hz = m && a != 0 && (a == b || a == c);
    e_frz = r && (m_fault || (m_wait ? !d : (q && !d)));
    e_br = r && !e_frz && t;
    e_lus = r && !e_frz && !t && hz;
    chk("pc_en", pc_en, r && !e_frz && !e_lus);
    chk("IF_ID_en", IF_ID_en, r && !e_frz && !e_lus);
    chk("ID_EX_en", ID_EX_en, r && !e_frz);
    chk("EX_MEM_en", EX_MEM_en, r && !e_frz);
    chk("IF_ID_flush", IF_ID_flush, e_br);
    chk("ID_EX_flush", ID_EX_flush, e_br || e_lus);
    chk("MEM_WB_bubble", MEM_WB_bubble, !r || e_frz);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("mem_fault", mem_fault, m_fault);
  endtask
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      if ((e_frz || e_lus) && m_stall < SAT) m_stall++;
      if (e_br && m_flush < SAT) m_flush++;
      if (!m_fault) begin
        if (m_wait) begin
          if (rd) m_wait = 0;
          else begin
            m_k++;
            if (m_k > TMO) begin m_fault = 1; m_wait = 0; end
          end
        end else if (rq && !rd) begin
          m_wait = 1; m_k = 1;
        end
      end
    end
    @(negedge clock);
  endtask
  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_bubble", MEM_WB_bubble, 1);
    chk("rst_pc_en", pc_en, 0);
    tick();
    idle();
    chk("run_pc_en", pc_en, 1);
    chk("run_bubble", MEM_WB_bubble, 0);
    chk("run_stall", stall_cnt, 0);
    tick();
    drive(1, 1, 8, 8, 3, 0, 0, 0);
    chk("lu_pc_en", pc_en, 0);
    chk("lu_ifid_en", IF_ID_en, 0);
    chk("lu_idex_flush", ID_EX_flush, 1);
    tick();
    idle();
    chk("lu_stall", stall_cnt, 1);
    chk("lu_clear", pc_en, 1);
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk("lu_r0_pc_en", pc_en, 1);
    tick();
    drive(1, 1, 8, 2, 8, 1, 0, 0);
    chk("br_ifid_flush", IF_ID_flush, 1);
    chk("br_idex_flush", ID_EX_flush, 1);
    chk("br_pc_en", pc_en, 1);
    tick();
    idle();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      chk("mw_bubble", MEM_WB_bubble, 1);
      chk("mw_pc_en", pc_en, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 1, 1, 1);
    chk("rel_ifid_flush", IF_ID_flush, 1);
    chk("rel_pc_en", pc_en, 1);
    chk("rel_bubble", MEM_WB_bubble, 0);
    tick();
    idle();
    chk("rel_run", pc_en, 1);
    chk("rel_stall", stall_cnt, 4);
    chk("rel_flush", flush_cnt, 2);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      chk("to_nofault", mem_fault, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    chk("to_fault", mem_fault, 1);
    chk("to_freeze", pc_en, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      drive(1, 0, 0, 0, 0, 1, 1, 1);
    end
    chk("sat_stall", stall_cnt, 15);
    chk("sat_fault", mem_fault, 1);
    chk("sat_flushes", IF_ID_flush, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("rrst_fault", mem_fault, 0);
    chk("rrst_stall", stall_cnt, 0);
    tick();
    idle();
    chk("rrst_run", pc_en, 1);
    tick();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(39) != 0, 1'($urandom_range(1)), $urandom_range(3), $urandom_range(3),
            $urandom_range(3), $urandom_range(3) == 0, $urandom_range(2) == 0, 1'($urandom_range(1)));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and flush controls of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves three conditions: load-use hazards (1-cycle bubble), taken branches/jumps (flush of the younger stages) and multi-cycle data-memory accesses (whole-pipe freeze with timeout). It also keeps saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before FAULT (1..2^CNT_W-1)
CNT_W, 4, width of wait counter
PERF_W, 16, width of performance counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_rt  in  5  load destination register
IF_ID_rs  in  5  source reg of instruction in ID
IF_ID_rt  in  5  second source reg of instruction in ID
branch_taken  in  1  EX-stage redirect (branch taken or jump)
dm_req  in  1  MEM-stage instruction accesses data memory
dm_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC load enable
IF_ID_en  out  1  IF_ID capture enable
ID_EX_en  out  1  ID_EX capture enable
EX_MEM_en  out  1  EX_MEM capture enable
IF_ID_flush  out  1  IF_ID loads NOP
ID_EX_flush  out  1  ID_EX loads bubble (all control signals 0)
MEM_WB_bubble  out  1  MEM_WB loads RegWrite=0, MemtoReg=0, PctoReg=0
mem_fault  out  1  sticky memory-timeout flag
stall_cnt  out  PERF_W  cycles with pc_en=0, saturating
flush_cnt  out  PERF_W  branch flush events, saturating

Behaviour:
- States: RUN, MEM_WAIT, FAULT. The reset value is RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_fault=0.
- While reset=0, the combinational outputs are: all *_en=0, IF_ID_flush=0, ID_EX_flush=0, MEM_WB_bubble=1.
- Derived signals:
  - lu = ID_EX_MemRead & (ID_EX_rt!=0) & (ID_EX_rt==IF_ID_rs | ID_EX_rt==IF_ID_rt)
  - mw = dm_req & ~dm_ready
- Outputs are combinational from the state and the current inputs (zero-latency stall).
- The default (normal) output set is: all *_en=1, both flushes=0, MEM_WB_bubble=0.
- RUN priority is mw > branch_taken > lu:
  - mw: all *_en=0, MEM_WB_bubble=1. Next state MEM_WAIT, wait_cnt<=1.
  - branch_taken: normal enables, IF_ID_flush=1, ID_EX_flush=1, flush_cnt+1.
  - lu: pc_en=0, IF_ID_en=0, ID_EX_flush=1, ID_EX_en=1, EX_MEM_en=1. Stay in RUN. The bubble clears lu on the next cycle naturally.
  - none of the above: normal output set.
- MEM_WAIT:
  - dm_ready=0 and wait_cnt<MEM_TIMEOUT: freeze as above, wait_cnt+1.
  - dm_ready=0 and wait_cnt==MEM_TIMEOUT: freeze, next state FAULT, mem_fault<=1.
  - dm_ready=1 (release cycle): outputs are evaluated exactly as RUN with mw=0, so a pending branch_taken or lu acts in this same cycle. Next state RUN, wait_cnt<=0.
- FAULT: all *_en=0, MEM_WB_bubble=1, flushes=0. The state is left only by reset.
- dm_req & dm_ready in RUN is a single-cycle access and causes no stall.
- branch_taken asserted during MEM_WAIT is ignored until the release cycle. EX_MEM is frozen, so the inputs stay stable.
- stall_cnt increments in every non-reset cycle with pc_en=0 (including FAULT) and saturates at all-ones. flush_cnt saturates likewise.
- Reset asserted mid-operation (any state) returns to RUN immediately and asynchronously. All counters and mem_fault clear.
- Constraint: 1 ≤ MEM_TIMEOUT < 2^CNT_W.

Test Plan:
- Reset low, then high in RUN with no hazards -> all *_en=1, flushes=0, MEM_WB_bubble=0, stall_cnt=0.
- ID_EX_MemRead=1, ID_EX_rt=8, IF_ID_rs=8 for one cycle, then the bubble clears MemRead -> exactly 1 cycle with pc_en=0, IF_ID_en=0, ID_EX_flush=1; stall_cnt=1. Repeat with ID_EX_rt=0 -> no stall.
- branch_taken=1 together with lu=1 -> IF_ID_flush=1, ID_EX_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- dm_req=1, dm_ready low for 3 cycles then high, with branch_taken=1 on the release cycle -> 3 frozen cycles with MEM_WB_bubble=1; release cycle has flushes=1 and enables=1; state RUN; stall_cnt=3.
- MEM_TIMEOUT=4, dm_req=1, dm_ready held 0 -> FAULT entered after the 4th wait cycle; mem_fault=1 stays sticky with dm_ready=1; reset pulse low -> RUN, mem_fault=0, counters 0.
- Force stall_cnt to saturation (PERF_W=4 build, 20 stall cycles) -> stall_cnt holds 15.
